// File: rtl/serial_add_sequencer.sv
// Control sequencer for a WIDTH-bit serial add/accumulate datapath: serialises an
// operand LSB-first onto the datapath, then runs the add phase and returns the accumulator.
module serial_add_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_clear,
    input  logic [WIDTH-1:0] in_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             busy,
    output logic             se,
    output logic             si,
    output logic             dp_rstn,
    input  logic [WIDTH-1:0] acc_in,
    input  logic             carry_in
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        ADD,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             se_q, se_d;
    logic             si_q, si_d;
    logic             dp_rstn_q, dp_rstn_d;
    logic             res_valid_q, res_valid_d;
    logic             in_ready_q, in_ready_d;

    logic cnt_last;
    assign cnt_last = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    op_d    = in_op;
                    cnt_d   = '0;
                    state_d = in_clear ? CLR : LOAD;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = LOAD;
            end
            LOAD: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ADD: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (res_valid_q && res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with the state flop.
        se_d        = (state_d == LOAD) || (state_d == ADD);
        si_d        = (state_d == LOAD) ? op_d[cnt_d] : 1'b0;
        dp_rstn_d   = (state_d != CLR);
        res_valid_d = (state_d == RESP);
        in_ready_d  = (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            se_q        <= 1'b0;
            si_q        <= 1'b0;
            dp_rstn_q   <= 1'b0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            se_q        <= se_d;
            si_q        <= si_d;
            dp_rstn_q   <= dp_rstn_d;
            res_valid_q <= res_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign se        = se_q;
    assign si        = si_q;
    assign dp_rstn   = dp_rstn_q;
    assign busy      = (state_q != IDLE);

    // Safe pass-through: the datapath holds still while se is low in RESP.
    assign res_sum   = acc_in;
    assign res_carry = carry_in;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Bench for serial_add_sequencer: behavioural serial-adder datapath plus a scoreboard
// whose monitor checks every returned result and its latency against hand-computed values.
module tb_serial_add_sequencer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             in_clear = 1'b0;
    logic [WIDTH-1:0] in_op = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] res_sum;
    logic             res_carry;
    logic             busy;
    logic             se;
    logic             si;
    logic             dp_rstn;
    logic [WIDTH-1:0] acc_in;
    logic             carry_in;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_clear  (in_clear),
        .in_op     (in_op),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .busy      (busy),
        .se        (se),
        .si        (si),
        .dp_rstn   (dp_rstn),
        .acc_in    (acc_in),
        .carry_in  (carry_in)
    );

    // Serial-adder datapath: A and B shift right, the sum bit enters A at the MSB, SI enters B.
    logic [WIDTH-1:0] dp_a, dp_b;
    logic             dp_c;

    always @(posedge clk or negedge dp_rstn) begin
        if (!dp_rstn) begin
            dp_a <= '0;
            dp_b <= '0;
            dp_c <= 1'b0;
        end else if (se) begin
            dp_a <= {dp_a[0] ^ dp_b[0] ^ dp_c, dp_a[WIDTH-1:1]};
            dp_b <= {si, dp_b[WIDTH-1:1]};
            dp_c <= (dp_a[0] & dp_b[0]) | (dp_c & (dp_a[0] ^ dp_b[0]));
        end
    end

    assign acc_in   = dp_a;
    assign carry_in = dp_c;

    typedef struct {
        int sum;
        int carry;
        int lat;
        int acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp   = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   hs_edge = -1;
    int   n_res   = 0;
    int   n_push  = 0;
    logic rv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: latency on the rising edge of res_valid, sum/carry on each handshake.
    always @(negedge clk) begin
        if (rst) begin
            rv_prev = 1'b0;
        end else begin
            if (res_valid && !rv_prev) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: got sum %0d with no pending request, expected none", res_sum);
                end else begin
                    // Latency counts the accept edge itself.
                    check("latency", cyc - exp_q[0].acc_cyc + 1, exp_q[0].lat);
                end
            end
            if (res_valid && res_ready && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_sum", int'(res_sum), e.sum);
                check("res_carry", int'(res_carry), e.carry);
                n_res++;
                hs_edge = cyc + 1;
            end
            rv_prev = res_valid;
        end
    end

    task automatic send(input logic [WIDTH-1:0] op, input logic clr, input logic push,
                        input int es, input int ec, input logic hold, output int acc);
        int n;
        exp_t e;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_op    = op;
        in_clear = clr;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", n);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        @(posedge clk);
        #1;
        acc = cyc;
        if (push) begin
            e.sum     = es;
            e.carry   = ec;
            e.lat     = 2 * WIDTH + 1 + int'(clr);
            e.acc_cyc = acc;
            exp_q.push_back(e);
            n_push++;
        end
        if (!hold) begin
            in_valid = 1'b0;
            in_clear = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() != 0 || busy) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results pending, busy=%0d, expected 0/0", exp_q.size(), busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, a1, a2, a3, n;
        logic [3:0] si_exp;

        // 1. Reset for three edges, then release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_dp_rstn", int'(dp_rstn), 0);
        check("rst_se", int'(se), 0);
        check("rst_res_valid", int'(res_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_dp_rstn", int'(dp_rstn), 0);
        check("release_in_ready", int'(in_ready), 0);
        @(negedge clk);
        check("idle_dp_rstn", int'(dp_rstn), 1);
        check("idle_in_ready", int'(in_ready), 1);
        check("idle_se", int'(se), 0);
        check("idle_res_valid", int'(res_valid), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_acc", int'(acc_in), 0);

        // 2. Clear + 9: one CLR cycle, eight shift cycles, si = 1,0,0,1 during LOAD.
        send(4'd9, 1'b1, 1'b1, 9, 0, 1'b0, a0);
        @(negedge clk);
        check("clr_dp_rstn", int'(dp_rstn), 0);
        check("clr_se", int'(se), 0);
        check("clr_busy", int'(busy), 1);
        si_exp = 4'b1001;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            check("shift_se", int'(se), 1);
            check("shift_dp_rstn", int'(dp_rstn), 1);
            check("shift_si", int'(si), (i < WIDTH) ? int'(si_exp[i]) : 0);
        end
        @(negedge clk);
        check("resp_se", int'(se), 0);
        check("resp_valid", int'(res_valid), 1);
        drain();

        // 3. 9 + 9 = 18 -> 2 carry 1; then 1 folds the carry: 2 + 1 + 1 = 4.
        send(4'd9, 1'b0, 1'b1, 2, 1, 1'b0, a0);
        send(4'd1, 1'b0, 1'b1, 4, 0, 1'b0, a0);
        drain();

        // 4. Stall in RESP for five cycles with a stray in_valid pulse: 4 + 2 = 6.
        send(4'd2, 1'b0, 1'b1, 6, 0, 1'b0, a0);
        res_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stall_reached_resp", int'(res_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = (i == 2);
            in_op    = 4'hF;
            @(negedge clk);
            check("stall_valid", int'(res_valid), 1);
            check("stall_sum", int'(res_sum), 6);
            check("stall_se", int'(se), 0);
            check("stall_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        drain();
        repeat (20) @(negedge clk);
        check("stray_busy", int'(busy), 0);
        check("stray_acc", int'(acc_in), 6);

        // 5. Reset during LOAD with cnt = 2 (op 6, bit 2 is 1); partial op is discarded.
        send(4'd6, 1'b0, 1'b0, 0, 0, 1'b0, a0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("midload_se", int'(se), 1);
        check("midload_si", int'(si), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_se", int'(se), 0);
        check("midrst_dp_rstn", int'(dp_rstn), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_res_valid", int'(res_valid), 0);
        @(negedge clk);
        check("midrst_acc", int'(acc_in), 0);
        check("midrst_carry", int'(carry_in), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        send(4'd5, 1'b1, 1'b1, 5, 0, 1'b0, a0);
        drain();

        // 6. Back-to-back after clear: 3, 3+4 = 7, 7+5 = 12.
        send(4'd3, 1'b1, 1'b1, 3, 0, 1'b1, a1);
        send(4'd4, 1'b0, 1'b1, 7, 0, 1'b1, a2);
        check("b2b_accept_gap_2", a2 - hs_edge, 1);
        send(4'd5, 1'b0, 1'b1, 12, 0, 1'b0, a3);
        check("b2b_accept_gap_3", a3 - hs_edge, 1);
        check("b2b_period", a3 - a2, 2 * WIDTH + 2);
        drain();

        repeat (5) @(negedge clk);
        check("result_count", n_res, n_push);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
